// File: rtl/axi_line_pkg.sv
// axi_line_pkg: shared types and constants for the AXI line master
package axi_line_pkg;
  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_RSP} state_t;
  typedef logic [127:0] line_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam int LINE_WORDS = 4;
  localparam logic [2:0] SIZE_WORD = 3'b010;
endpackage

// File: rtl/axi_line_master_if.sv
// axi_line_master_if: AXI4 read/write channel bundle with master and slave views
interface axi_line_master_if;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, arready;
  logic [3:0] rid;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic [3:0] awid;
  logic [31:0] awaddr;
  logic [3:0] awlen;
  logic [2:0] awsize;
  logic [1:0] awburst;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic [3:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready;
  modport master(
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
  modport slave(
    input arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input awid, awaddr, awlen, awsize, awburst, awvalid,
    input wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_line_buf.sv
// axi_line_buf: four-word line register with per-beat write and whole-line load/read
module axi_line_buf
  import axi_line_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [1:0]  i_idx,
  input  logic [31:0] i_wdata,
  input  logic        i_load,
  input  line_t       i_line,
  output line_t       o_line
);
  logic [31:0] r_mem [LINE_WORDS];
  // whole-line load takes priority over a single beat write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LINE_WORDS; k++) r_mem[k] <= '0;
    end else if (i_load) begin
      for (int k = 0; k < LINE_WORDS; k++) r_mem[k] <= i_line[32*k +: 32];
    end else if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end
  // flatten the word array into the line view
  always_comb begin
    o_line = '0;
    for (int k = 0; k < LINE_WORDS; k++) o_line[32*k +: 32] = r_mem[k];
  end
endmodule

// File: rtl/axi_line_master.sv
// axi_line_master: moves 16-byte lines over AXI4 as 4-beat bursts; AXI_WRAP_REFILL_EN selects critical-word-first WRAP refills
module axi_line_master
  import axi_line_pkg::*;
#(
  parameter logic [3:0] MASTER_ID = 4'h0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_write,
  input  logic [31:0]        i_req_addr,
  input  line_t              i_req_wline,
  output logic               o_rsp_valid,
  output line_t              o_rsp_rline,
  output logic               o_rsp_err,
  axi_line_master_if.master  m_axi
);
`ifdef AXI_WRAP_REFILL_EN
  localparam logic [31:0] AR_MASK = ~32'h3;
  localparam logic [1:0]  AR_BURST = BURST_WRAP;
`else
  localparam logic [31:0] AR_MASK = ~32'hF;
  localparam logic [1:0]  AR_BURST = BURST_INCR;
`endif
  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic        r_write, r_err, r_full;
  logic [1:0]  r_cnt;
  line_t       r_rline, w_line;
  logic [1:0]  w_start, w_idx;
  logic        w_accept, w_beat, w_whs;

  assign w_accept = (r_state == S_IDLE) & i_req_valid;
  assign w_beat   = (r_state == S_R) & m_axi.rvalid;
  assign w_whs    = (r_state == S_W) & m_axi.wready;
`ifdef AXI_WRAP_REFILL_EN
  assign w_start  = r_addr[3:2];
`else
  assign w_start  = 2'b00;
`endif
  assign w_idx       = w_start + r_cnt;
  assign o_rsp_err   = r_err;
  assign o_rsp_rline = (r_state == S_RSP && !r_write) ? w_line : r_rline;

  axi_line_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_beat),
    .i_idx   (w_idx),
    .i_wdata (m_axi.rdata),
    .i_load  (w_accept & i_req_write),
    .i_line  (i_req_wline),
    .o_line  (w_line)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  // next state and all AXI/request outputs, zero outside their owning state
  always_comb begin
    w_next = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    m_axi.arid = '0;
    m_axi.araddr = '0;
    m_axi.arlen = '0;
    m_axi.arsize = '0;
    m_axi.arburst = '0;
    m_axi.arvalid = 1'b0;
    m_axi.rready = 1'b0;
    m_axi.awid = '0;
    m_axi.awaddr = '0;
    m_axi.awlen = '0;
    m_axi.awsize = '0;
    m_axi.awburst = '0;
    m_axi.awvalid = 1'b0;
    m_axi.wdata = '0;
    m_axi.wstrb = '0;
    m_axi.wlast = 1'b0;
    m_axi.wvalid = 1'b0;
    m_axi.bready = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = i_req_write ? S_AW : S_AR;
      end
      S_AR: begin
        m_axi.arvalid = 1'b1;
        m_axi.arid = MASTER_ID;
        m_axi.araddr = r_addr & AR_MASK;
        m_axi.arlen = 4'd3;
        m_axi.arsize = SIZE_WORD;
        m_axi.arburst = AR_BURST;
        if (m_axi.arready) w_next = S_R;
      end
      S_R: begin
        m_axi.rready = 1'b1;
        if (m_axi.rvalid && m_axi.rlast) w_next = S_RSP;
      end
      S_AW: begin
        m_axi.awvalid = 1'b1;
        m_axi.awid = MASTER_ID;
        m_axi.awaddr = r_addr & ~32'hF;
        m_axi.awlen = 4'd3;
        m_axi.awsize = SIZE_WORD;
        m_axi.awburst = BURST_INCR;
        if (m_axi.awready) w_next = S_W;
      end
      S_W: begin
        m_axi.wvalid = 1'b1;
        m_axi.wstrb = 4'hF;
        m_axi.wdata = w_line[{r_cnt, 5'b0} +: 32];
        m_axi.wlast = (r_cnt == 2'd3);
        if (m_axi.wready && r_cnt == 2'd3) w_next = S_B;
      end
      S_B: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) w_next = S_RSP;
      end
      S_RSP: begin
        o_rsp_valid = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // request capture, beat counting, error accumulation and refill line hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_write <= 1'b0;
      r_err <= 1'b0;
      r_full <= 1'b0;
      r_cnt <= '0;
      r_rline <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= i_req_addr;
        r_write <= i_req_write;
        r_err <= 1'b0;
        r_full <= 1'b0;
        r_cnt <= '0;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 2'd1;
        r_full <= r_full | (r_cnt == 2'd3);
        r_err <= r_err | (m_axi.rresp != RESP_OKAY) | (m_axi.rid != MASTER_ID) | r_full
                 | (m_axi.rlast & (r_cnt != 2'd3));
      end
      if (w_whs) r_cnt <= r_cnt + 2'd1;
      if (r_state == S_B && m_axi.bvalid)
        r_err <= r_err | (m_axi.bresp != RESP_OKAY) | (m_axi.bid != MASTER_ID);
      if (r_state == S_RSP && !r_write) r_rline <= w_line;
    end
  end
endmodule

// File: doc/axi_line_master.md
# axi_line_master

AXI4 master that moves whole 16-byte cache lines between a cache controller and the AXI slaves (SRAM wrappers) through the interconnect. It accepts one line request at a time: a refill becomes a 4-beat read burst and a write-back a 4-beat write burst. It returns the assembled line, or completion, with an error flag. It sits directly upstream of the SRAM wrapper, on the master side of the interconnect.

## Interface
- MASTER_ID, 4'h0, value driven on arid/awid and expected on rid/bid
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid / req_ready  in/out  1  request handshake; req_ready = (state==IDLE)
- req_write  in  1  1 = write-back, 0 = refill
- req_addr  in  32  byte address inside target line
- req_wline  in  128  write-back line, word k at bits [32k+31:32k]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rline  out  128  refilled line (valid with rsp_valid for refills)
- rsp_err  out  1  any SLVERR/DECERR, ID mismatch or beat-count error
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/4/3/2/1 ; arready in 1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1 ; rready out 1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1 ; awready in 1
- wdata/wstrb/wlast/wvalid  out  32/4/1/1 ; wready in 1
- bid/bresp/bvalid  in  4/2/1 ; bready out 1

## Operation
- States: IDLE, AR, R, AW, W, B, RSP.
- IDLE: req_valid&req_ready latches addr, write flag, wline; clears err and beat counter.
  - Goes to AW if write, else AR.
- AR: arvalid=1, arlen=3, arsize=3'b010, arid=MASTER_ID; araddr and arburst per Configuration. Holds until arready, then R.
- R: rready=1. Each rvalid beat:
  - writes rdata into line word idx; idx = (start+cnt) mod 4.
  - ORs err with (rresp!=OKAY) | (rid!=MASTER_ID).
  - rlast terminates the burst → RSP. err is also set if the beat count is not 4.
  - Beats after the 4th overwrite modulo 4 and set err.
- AW: awaddr = {req_addr[31:4],4'h0}, awburst=INCR, awlen=3, awsize=3'b010. Holds until awready, then W. W is never issued before the AW handshake.
- W: wvalid=1, wstrb=4'hF, wdata=word cnt, wlast=(cnt==3). cnt advances only on wready. The last handshake → B.
- B: bready=1. On bvalid, err |= (bresp!=OKAY)|(bid!=MASTER_ID) → RSP.
- RSP: rsp_valid=1 for exactly one cycle → IDLE. rsp_rline holds until the next refill starts.
- AXI outputs hold stable while valid&!ready.
- Unused AXI outputs are 0 outside their state.

## Timing
- Reset (async): state IDLE, all valids/readies 0 except req_ready=1; rsp_valid=0, rsp_err=0, rsp_rline=0, counters 0.
- Request accepted at edge T: arvalid/awvalid high in cycle T+1.
- Zero-wait slave:
  - refill: AR T+1, R beats T+2..T+5, rsp_valid T+6.
  - write-back: AW T+1, W T+2..T+5, B T+6, rsp_valid T+7.
- Back-to-back: req_ready high the cycle after rsp_valid. Minimum request spacing is 7 (refill) or 8 (write-back) cycles.
- Reset mid-burst aborts immediately. No beat is replayed.
- rready and bready are not gated by internal space. Line storage always has room.

## Configuration
- AXI_WRAP_REFILL_EN defined:
  - Refills use arburst=WRAP and araddr={req_addr[31:2],2'b00} (critical word first).
  - Word index starts at req_addr[3:2] and wraps 3→0.
- Undefined:
  - arburst=INCR and araddr={req_addr[31:4],4'h0}.
  - Index starts at 0.
- Write-backs are INCR/aligned in both builds.

## Structure
- Shared package axi_line_pkg:
  - state enum (3-bit)
  - BURST_INCR/BURST_WRAP
  - RESP_OKAY
  - LINE_WORDS=4
  - SIZE_WORD=3'b010
  - line_t (logic [127:0])
- Sub-module axi_line_buf: 4×32 register array with beat write (en, idx, data), 128-bit parallel load and 128-bit parallel read. Instantiated once; refill writes it, write-back loads it from req_wline.

## Test plan
- Refill of addr 0x0001_0008, slave returns 0xA0..0xA3, OKAY, zero wait → rsp_rline word0..3 = A0..A3 at T+6, rsp_err=0.
- Same with AXI_WRAP_REFILL_EN → araddr=0x0001_0008, arburst=WRAP; beats A2,A3,A0,A1 land in words 2,3,0,1.
- Write-back 0x0000_2010, wready low on beat 1 for 3 cycles → wdata/wlast stable while stalled, wlast only on 4th beat, rsp_valid after B.
- Refill with rresp=SLVERR on beat 2 → all 4 beats accepted, rsp_err=1; also bid=MASTER_ID+1 on write → rsp_err=1.
- rlast on 3rd beat → RSP next cycle, rsp_err=1; rst low during W state → all valids 0 immediately, req_ready=1 after release.
